// File: rtl/debug_step_ctrl_pkg.sv
// Shared definitions for the debug step controller: FSM state encoding and
// a width helper used to size the debounce and run-divider counters.
package debug_step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_STEP   = 2'd1,
        ST_RUN    = 2'd2
    } ctrl_state_e;

    // Bits needed to hold every value in 0..maxVal, never less than one.
    function automatic int unsigned ctrWidth(input int unsigned maxVal);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) <= 64'(maxVal)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debug_step_ctrl_button_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter that only
// accepts a new level after DEBOUNCE_CYCLES agreeing samples, and a press pulse.
module button_debounce
    import debug_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int unsigned CW = ctrWidth(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          levelPrev_q;
    logic          press_q;

    // Any sample agreeing with the accepted level restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            levelPrev_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= btn_in;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            levelPrev_q <= level_q;
            press_q     <= level_q & ~levelPrev_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/debug_step_ctrl.sv
// Pipeline clock-enable controller: single-step or free-run from two debounced
// buttons. Define STEP_COUNT_EN to build the enable counter; otherwise step_count is 0.
module debug_step_ctrl
    import debug_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned RUN_DIV         = 10,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_step,
    input  logic             btn_run,
    output logic             cpu_en,
    output logic             running,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned DIV_W = ctrWidth(RUN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic stepPress;
    logic runPress;
    logic unusedStepLevel;
    logic unusedRunLevel;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uStepBtn (
        .clk   (clk),
        .reset (reset),
        .btn_in(btn_step),
        .level (unusedStepLevel),
        .press (stepPress)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uRunBtn (
        .clk   (clk),
        .reset (reset),
        .btn_in(btn_run),
        .level (unusedRunLevel),
        .press (runPress)
    );

    ctrl_state_e      state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             cpuEn_q;
    logic             running_q;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    // Outputs are registered alongside the state, so cpu_en lines up with the
    // cycle the FSM sits in STEP or the divider sits on its terminal value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_PAUSED;
            div_q     <= '0;
            cpuEn_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                ST_PAUSED: begin
                    div_q <= '0;
                    if (runPress) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                        cpuEn_q   <= (RUN_DIV == 1);
                    end else if (stepPress) begin
                        state_q   <= ST_STEP;
                        running_q <= 1'b0;
                        cpuEn_q   <= 1'b1;
                    end else begin
                        state_q   <= ST_PAUSED;
                        running_q <= 1'b0;
                        cpuEn_q   <= 1'b0;
                    end
                end
                ST_STEP: begin
                    state_q   <= ST_PAUSED;
                    div_q     <= '0;
                    running_q <= 1'b0;
                    cpuEn_q   <= 1'b0;
                end
                ST_RUN: begin
                    if (runPress) begin
                        state_q   <= ST_PAUSED;
                        div_q     <= '0;
                        running_q <= 1'b0;
                        cpuEn_q   <= 1'b0;
                    end else begin
                        state_q   <= ST_RUN;
                        div_q     <= div_d;
                        running_q <= 1'b1;
                        cpuEn_q   <= (div_d == DIV_LAST);
                    end
                end
                default: begin
                    state_q   <= ST_PAUSED;
                    div_q     <= '0;
                    running_q <= 1'b0;
                    cpuEn_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_en  = cpuEn_q;
    assign running = running_q;

`ifdef STEP_COUNT_EN
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Wraps silently; the display path only shows the low digits anyway.
    always_comb begin
        count_d = cpuEn_q ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign step_count = count_q;
`else
    assign step_count = '0;
`endif

endmodule
